tekbot_drive_fsm: RTL and testbench
===================================

# tekbot_drive_fsm

Autonomous drive controller for the TekBot, the successor to the combinational bump/direction decoder. It samples the left and right whisker switches and runs a timed back-up-and-turn manoeuvre on each collision. It drives both motor channels through a shared PWM speed stage and exposes a manual direction override. It sits between the whisker/analog-direction inputs and the H-bridge enable/direction pins.

## Interface
- BACK_CYCLES, 50_000_000 — clocks spent reversing after a bump; ≥1
- TURN_CYCLES, 25_000_000 — clocks spent pivoting after reversing; ≥1
- CNT_W, 27 — manoeuvre timer width; must hold max(BACK_CYCLES, TURN_CYCLES)-1
- PWM_W, 8 — speed/PWM counter width
- EVT_W, 8 — bump event counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  1 = autonomous driving enabled
- bump_l_n, bump_r_n  in  1 each  whisker switches, active-low, asynchronous
- manual_sel  in  1  1 = manual override
- manual_ldir, manual_rdir  in  1 each  manual direction, 1 = forward
- speed  in  PWM_W  duty setting
- Len, Ren  out  1 each  motor enables
- Ldir, Rdir  out  1 each  motor directions, 1 = forward
- state  out  2  IDLE=0, FWD=1, BACK=2, TURN=3
- turn_right  out  1  pending/active pivot direction
- bump_cnt  out  EVT_W  saturating count of accepted bumps

## Operation
- Each whisker passes through a 2-flop synchronizer. Synchronizer reset value is 1 (no bump). A bump is a synchronized value of 0.
- PWM: a free-running PWM_W counter that wraps. pwm_on = (pwm_cnt < speed). Exception: speed all-ones gives pwm_on = 1 constantly. speed = 0 gives pwm_on = 0 constantly.
- State IDLE:
  - Outputs: Len=Ren=0, Ldir=Rdir=1.
  - Transition: run=1 → FWD.
- State FWD:
  - Outputs: Len=Ren=pwm_on, Ldir=Rdir=1.
  - Transition on any bump → BACK. The timer loads BACK_CYCLES-1 and bump_cnt increments.
  - turn_right is set as follows: left only → 1; right only → 0; both → the inverse of the previous both-bump choice. A toggle register holds that choice; its reset value selects right first.
- State BACK:
  - Outputs: Len=Ren=pwm_on, Ldir=Rdir=0.
  - The timer decrements each clock. At timer = 0 → TURN, and the timer loads TURN_CYCLES-1.
- State TURN:
  - turn_right=1 → Ldir=1, Rdir=0; turn_right=0 → Ldir=0, Rdir=1. Enables are pwm_on.
  - At timer = 0 → FWD.
- Bumps during BACK or TURN are ignored and not counted.
- run=0 in any state → IDLE on the next edge. This aborts any manoeuvre and clears the timer. It has priority over every other transition.
- manual_sel=1:
  - The output decode is overridden combinationally: Len=Ren=pwm_on, Ldir=manual_ldir, Rdir=manual_rdir.
  - The FSM is forced to IDLE next edge and the timer is cleared.
  - On release, the normal run rule applies.
- bump_cnt saturates at all-ones. It does not wrap.
- turn_right holds its value outside BACK/TURN.

## Timing
- Reset (synchronous, one edge) sets:
  - state=IDLE, timer=0, pwm_cnt=0, bump_cnt=0, turn_right=1, toggle=right, synchronizers=1.
  - With manual_sel=0, outputs become Len=Ren=0, Ldir=Rdir=1.
- Reset asserted mid-manoeuvre returns to IDLE on that edge, with no residual timer.
- Bump latency: a bump that goes low before edge k appears in state=BACK after edge k+2.
- BACK lasts exactly BACK_CYCLES clocks and TURN lasts exactly TURN_CYCLES clocks.
- run rising before edge k gives state=FWD after edge k.
- Outputs are combinational from registered state, turn_right and pwm_cnt, plus the manual inputs. There are no motor-output flops, so a manual change is visible the same cycle.

## Test plan
- Reset, then run=1, speed=0xFF → after one edge state=FWD, Len=Ren=1, Ldir=Rdir=1, bump_cnt=0.
- BACK_CYCLES=4, TURN_CYCLES=3, pulse bump_l_n low for 1 cycle → BACK for exactly 4 clocks with Ldir=Rdir=0, then TURN for 3 clocks with turn_right=1, Ldir=1, Rdir=0, then FWD. bump_cnt=1.
- Three simultaneous both-bump events from FWD → turn_right sequence 1,0,1. A bump_r_n pulse during BACK leaves bump_cnt unchanged.
- speed=0x40, PWM_W=8, state FWD → Len high for exactly 64 of every 256 clocks. speed=0 → Len never high.
- Mid-BACK, assert manual_sel with manual_ldir=0, manual_rdir=1 → same-cycle Ldir=0, Rdir=1. Next edge state=IDLE. Release manual_sel with run=1 → FWD with a fresh manoeuvre on the next bump.
- EVT_W=2, five accepted bumps → bump_cnt reads 1,2,3,3,3. Assert reset mid-TURN → next edge state=IDLE, bump_cnt=0, Len=Ren=0.

Source files
------------

// File: rtl/tekbot_drive_fsm.sv
// -----------------------------------------------------------------------------
// tekbot_drive_fsm
//
// Autonomous drive controller for the TekBot. Drives forward while enabled.
// On a whisker collision it reverses for BACK_CYCLES clocks, then pivots away
// from the obstacle for TURN_CYCLES clocks, then resumes driving forward. Both
// motor enables are gated by a shared PWM speed stage. A manual override
// replaces the direction decode combinationally and parks the FSM in IDLE.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   run          1 = autonomous driving enabled
//   bump_l_n     left whisker, active-low, asynchronous
//   bump_r_n     right whisker, active-low, asynchronous
//   manual_sel   1 = manual override of motor directions
//   manual_ldir  manual left direction, 1 = forward
//   manual_rdir  manual right direction, 1 = forward
//   speed        PWM duty setting (all-ones = always on, 0 = always off)
//   Len, Ren     motor enables
//   Ldir, Rdir   motor directions, 1 = forward
//   state        IDLE=0, FWD=1, BACK=2, TURN=3
//   turn_right   pending/active pivot direction
//   bump_cnt     saturating count of accepted bumps
// -----------------------------------------------------------------------------
module tekbot_drive_fsm #(
  parameter int BACK_CYCLES = 50_000_000,
  parameter int TURN_CYCLES = 25_000_000,
  parameter int CNT_W       = 27,
  parameter int PWM_W       = 8,
  parameter int EVT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             bump_l_n,
  input  logic             bump_r_n,
  input  logic             manual_sel,
  input  logic             manual_ldir,
  input  logic             manual_rdir,
  input  logic [PWM_W-1:0] speed,
  output logic             Len,
  output logic             Ren,
  output logic             Ldir,
  output logic             Rdir,
  output logic [1:0]       state,
  output logic             turn_right,
  output logic [EVT_W-1:0] bump_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_BACK = 2'd2;
  localparam logic [1:0] S_TURN = 2'd3;

  // The timer counts down to zero inclusive, so loading N-1 gives N clocks.
  localparam logic [CNT_W-1:0] BACK_LOAD = CNT_W'(BACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  // Registered state
  logic [1:0]       sync_l_q, sync_r_q;
  logic [PWM_W-1:0] pwm_cnt_q;
  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] timer_q,      timer_d;
  logic             turn_right_q, turn_right_d;
  logic             toggle_q,     toggle_d;   // pivot choice for the next both-whisker bump
  logic [EVT_W-1:0] bump_cnt_q,   bump_cnt_d;

  logic bump_l, bump_r;
  logic pwm_on;

  // A synchronized 0 means the whisker is pressed.
  assign bump_l = ~sync_l_q[1];
  assign bump_r = ~sync_r_q[1];

  // All-ones is treated as full duty; the plain compare would leave one gap
  // per PWM period.
  assign pwm_on = (speed == {PWM_W{1'b1}}) || (pwm_cnt_q < speed);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    timer_d      = timer_q;
    turn_right_d = turn_right_q;
    toggle_d     = toggle_q;
    bump_cnt_d   = bump_cnt_q;

    if (!run || manual_sel) begin
      // Disable or override aborts any manoeuvre and leaves no residual timer.
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FWD;

        S_FWD: begin
          if (bump_l || bump_r) begin
            state_d = S_BACK;
            timer_d = BACK_LOAD;
            if (!(&bump_cnt_q)) bump_cnt_d = bump_cnt_q + EVT_W'(1);
            if (bump_l && bump_r) begin
              // Head-on: alternate pivot direction so the robot cannot get
              // stuck repeating the same escape.
              turn_right_d = toggle_q;
              toggle_d     = ~toggle_q;
            end else begin
              // Pivot away from the side that was hit.
              turn_right_d = bump_l;
            end
          end
        end

        S_BACK: begin
          if (timer_q == '0) begin
            state_d = S_TURN;
            timer_d = TURN_LOAD;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end

        S_TURN: begin
          if (timer_q == '0) state_d = S_FWD;
          else               timer_d = timer_q - CNT_W'(1);
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here; it is only seen on a rising clock edge.
    if (reset) begin
      sync_l_q     <= 2'b11;
      sync_r_q     <= 2'b11;
      pwm_cnt_q    <= '0;
      state_q      <= S_IDLE;
      timer_q      <= '0;
      turn_right_q <= 1'b1;
      toggle_q     <= 1'b1;
      bump_cnt_q   <= '0;
    end else begin
      sync_l_q     <= {sync_l_q[0], bump_l_n};
      sync_r_q     <= {sync_r_q[0], bump_r_n};
      pwm_cnt_q    <= pwm_cnt_q + PWM_W'(1);
      state_q      <= state_d;
      timer_q      <= timer_d;
      turn_right_q <= turn_right_d;
      toggle_q     <= toggle_d;
      bump_cnt_q   <= bump_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Motor output decode (combinational; manual override wins)
  // ---------------------------------------------------------------------------
  always_comb begin
    Len  = pwm_on;
    Ren  = pwm_on;
    Ldir = 1'b1;
    Rdir = 1'b1;
    if (manual_sel) begin
      Ldir = manual_ldir;
      Rdir = manual_rdir;
    end else begin
      case (state_q)
        S_IDLE: begin
          Len = 1'b0;
          Ren = 1'b0;
        end
        S_BACK: begin
          Ldir = 1'b0;
          Rdir = 1'b0;
        end
        S_TURN: begin
          Ldir = turn_right_q;
          Rdir = ~turn_right_q;
        end
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign turn_right = turn_right_q;
  assign bump_cnt   = bump_cnt_q;

endmodule

// File: tb/tb_tekbot_drive_fsm.sv
// -----------------------------------------------------------------------------
// tb_tekbot_drive_fsm
//
// Directed scenarios plus a randomized run, all checked against a behavioural
// model that tracks the robot's phase and the clocks remaining in it.
// -----------------------------------------------------------------------------
module tb_tekbot_drive_fsm;

  localparam int BACK_CYCLES = 4;
  localparam int TURN_CYCLES = 3;
  localparam int CNT_W       = 4;
  localparam int PWM_W       = 8;
  localparam int EVT_W       = 2;
  localparam int CNT_MAX     = (1 << EVT_W) - 1;
  localparam int PWM_MOD     = 1 << PWM_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             run = 1'b0;
  logic             bump_l_n = 1'b1;
  logic             bump_r_n = 1'b1;
  logic             manual_sel = 1'b0;
  logic             manual_ldir = 1'b1;
  logic             manual_rdir = 1'b1;
  logic [PWM_W-1:0] speed = 8'hFF;
  logic             Len, Ren, Ldir, Rdir;
  logic [1:0]       state;
  logic             turn_right;
  logic [EVT_W-1:0] bump_cnt;

  logic [8:0]       obs;
  assign obs = {state, Len, Ren, Ldir, Rdir, turn_right, bump_cnt};

  int tests_run    = 0;
  int tests_failed = 0;

  tekbot_drive_fsm #(
    .BACK_CYCLES(BACK_CYCLES),
    .TURN_CYCLES(TURN_CYCLES),
    .CNT_W      (CNT_W),
    .PWM_W      (PWM_W),
    .EVT_W      (EVT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .bump_l_n   (bump_l_n),
    .bump_r_n   (bump_r_n),
    .manual_sel (manual_sel),
    .manual_ldir(manual_ldir),
    .manual_rdir(manual_rdir),
    .speed      (speed),
    .Len        (Len),
    .Ren        (Ren),
    .Ldir       (Ldir),
    .Rdir       (Rdir),
    .state      (state),
    .turn_right (turn_right),
    .bump_cnt   (bump_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: phase 0 idle, 1 forward, 2 reversing, 3 pivoting;
  // m_left is the number of clocks still to spend in the current manoeuvre.
  // ---------------------------------------------------------------------------
  int m_phase, m_left, m_cnt, m_tr, m_next_both, m_pwm;
  int m_hist_l[2], m_hist_r[2];   // whisker samples, [1] is the older one

  task automatic model_edge();
    int hit_l, hit_r;
    if (reset) begin
      m_phase = 0; m_left = 0; m_cnt = 0; m_tr = 1; m_next_both = 1; m_pwm = 0;
      m_hist_l[0] = 1; m_hist_l[1] = 1; m_hist_r[0] = 1; m_hist_r[1] = 1;
    end else begin
      hit_l = (m_hist_l[1] == 0) ? 1 : 0;
      hit_r = (m_hist_r[1] == 0) ? 1 : 0;
      m_hist_l[1] = m_hist_l[0]; m_hist_l[0] = int'(bump_l_n);
      m_hist_r[1] = m_hist_r[0]; m_hist_r[0] = int'(bump_r_n);
      m_pwm = (m_pwm + 1) % PWM_MOD;
      if (!run || manual_sel) begin
        m_phase = 0;
        m_left  = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (hit_l != 0 || hit_r != 0) begin
          m_phase = 2;
          m_left  = BACK_CYCLES;
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
          if (hit_l != 0 && hit_r != 0) begin
            m_tr        = m_next_both;
            m_next_both = 1 - m_next_both;
          end else begin
            m_tr = hit_l;
          end
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_phase == 2) begin
            m_phase = 3;
            m_left  = TURN_CYCLES;
          end else begin
            m_phase = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [8:0] model_out();
    logic on, en, ld, rd;
    on = (int'(speed) == PWM_MOD - 1) || (m_pwm < int'(speed));
    en = on;
    ld = 1'b1;
    rd = 1'b1;
    if (manual_sel) begin
      ld = manual_ldir;
      rd = manual_rdir;
    end else if (m_phase == 0) begin
      en = 1'b0;
    end else if (m_phase == 2) begin
      ld = 1'b0;
      rd = 1'b0;
    end else if (m_phase == 3) begin
      ld = (m_tr != 0);
      rd = (m_tr == 0);
    end
    return {2'(m_phase), en, en, ld, rd, (m_tr != 0), 2'(m_cnt)};
  endfunction

  // One clock: model follows the edge, outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bump_pulse(input logic l, input logic r);
    bump_l_n = ~l;
    bump_r_n = ~r;
    tick();
    bump_l_n = 1'b1;
    bump_r_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; run = 1'b0; manual_sel = 1'b0; speed = 8'hFF;
    tick();
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (obs !== {2'd0, 4'b0011, 1'b1, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected %b", obs, {2'd0, 4'b0011, 1'b1, 2'd0});
    end
    tests_run++;
    if (obs !== model_out()) begin
      tests_failed++;
      $display("FAIL reset_model: got %b expected %b", obs, model_out());
    end
  endtask

  task automatic test_run_fwd();
    run = 1'b1;
    tick();
    tests_run++;
    if (obs !== {2'd1, 4'b1111, 1'b1, 2'd0}) begin
      tests_failed++;
      $display("FAIL run_fwd: got %b expected %b", obs, {2'd1, 4'b1111, 1'b1, 2'd0});
    end
  endtask

  task automatic test_bump_left();
    bump_pulse(1'b1, 1'b0);
    tests_run++;
    if (state !== 2'd1) begin
      tests_failed++;
      $display("FAIL bump_latency_k: got state %0d expected 1", state);
    end
    tick();
    tests_run++;
    if (state !== 2'd1) begin
      tests_failed++;
      $display("FAIL bump_latency_k1: got state %0d expected 1", state);
    end
    tick();
    for (int i = 0; i < BACK_CYCLES; i++) begin
      tests_run++;
      if ({state, Ldir, Rdir} !== {2'd2, 2'b00}) begin
        tests_failed++;
        $display("FAIL back_cycle%0d: got %b expected %b", i, {state, Ldir, Rdir}, {2'd2, 2'b00});
      end
      tick();
    end
    for (int i = 0; i < TURN_CYCLES; i++) begin
      tests_run++;
      if ({state, turn_right, Ldir, Rdir} !== {2'd3, 3'b110}) begin
        tests_failed++;
        $display("FAIL turn_cycle%0d: got %b expected %b", i, {state, turn_right, Ldir, Rdir}, {2'd3, 3'b110});
      end
      tick();
    end
    tests_run++;
    if ({state, bump_cnt} !== {2'd1, 2'd1}) begin
      tests_failed++;
      $display("FAIL bump_left_done: got state %0d cnt %0d expected state 1 cnt 1", state, bump_cnt);
    end
  endtask

  task automatic test_both_bumps();
    int exp_tr[3];
    int exp_cnt[3];
    logic [EVT_W-1:0] cnt_at_back;
    exp_tr  = '{1, 0, 1};
    exp_cnt = '{2, 3, 3};
    for (int e = 0; e < 3; e++) begin
      bump_pulse(1'b1, 1'b1);
      tick();
      tick();
      tests_run++;
      if ({state, turn_right} !== {2'd2, exp_tr[e] != 0}) begin
        tests_failed++;
        $display("FAIL both_bump%0d: got state %0d tr %0d expected state 2 tr %0d", e, state, turn_right, exp_tr[e]);
      end
      cnt_at_back = bump_cnt;
      if (e == 0) begin
        bump_pulse(1'b0, 1'b1);   // lands while still reversing
        for (int i = 0; i < BACK_CYCLES + TURN_CYCLES - 2; i++) tick();
        tests_run++;
        if (bump_cnt !== cnt_at_back) begin
          tests_failed++;
          $display("FAIL ignored_bump_cnt: got %0d expected %0d", bump_cnt, cnt_at_back);
        end
        tick();
      end else begin
        for (int i = 0; i < BACK_CYCLES + TURN_CYCLES; i++) tick();
      end
      tests_run++;
      if ({state, bump_cnt} !== {2'd1, 2'(exp_cnt[e])}) begin
        tests_failed++;
        $display("FAIL both_done%0d: got state %0d cnt %0d expected state 1 cnt %0d", e, state, bump_cnt, exp_cnt[e]);
      end
    end
  endtask

  task automatic test_pwm();
    logic [PWM_W-1:0] duty[3];
    int exp_on[3];
    int on_cnt;
    duty   = '{8'h40, 8'h00, 8'hFF};
    exp_on = '{64, 0, 256};
    for (int d = 0; d < 3; d++) begin
      speed  = duty[d];
      #1;
      on_cnt = 0;
      for (int i = 0; i < PWM_MOD; i++) begin
        if (Len === 1'b1 && Ren === 1'b1) on_cnt++;
        tick();
      end
      tests_run++;
      if (on_cnt != exp_on[d] || state !== 2'd1) begin
        tests_failed++;
        $display("FAIL pwm_duty_%0h: got %0d on-clocks (state %0d) expected %0d", duty[d], on_cnt, state, exp_on[d]);
      end
    end
    tests_run++;
    if (obs !== model_out()) begin
      tests_failed++;
      $display("FAIL pwm_model: got %b expected %b", obs, model_out());
    end
  endtask

  task automatic test_manual();
    bump_pulse(1'b0, 1'b1);
    tick();
    tick();
    tick();
    manual_sel = 1'b1; manual_ldir = 1'b0; manual_rdir = 1'b1;
    #1;
    tests_run++;
    if ({state, Len, Ren, Ldir, Rdir} !== {2'd2, 4'b1101}) begin
      tests_failed++;
      $display("FAIL manual_same_cycle: got %b expected %b", {state, Len, Ren, Ldir, Rdir}, {2'd2, 4'b1101});
    end
    tick();
    tests_run++;
    if ({state, Ldir, Rdir} !== {2'd0, 2'b01}) begin
      tests_failed++;
      $display("FAIL manual_idle: got %b expected %b", {state, Ldir, Rdir}, {2'd0, 2'b01});
    end
    manual_sel = 1'b0;
    #1;
    tests_run++;
    if ({Len, Ren, Ldir, Rdir} !== 4'b0011) begin
      tests_failed++;
      $display("FAIL manual_release: got %b expected 0011", {Len, Ren, Ldir, Rdir});
    end
    tick();
    tests_run++;
    if (state !== 2'd1) begin
      tests_failed++;
      $display("FAIL manual_resume: got state %0d expected 1", state);
    end
    bump_pulse(1'b1, 1'b0);
    tick();
    tick();
    for (int i = 0; i < BACK_CYCLES; i++) begin
      tests_run++;
      if (state !== 2'd2) begin
        tests_failed++;
        $display("FAIL fresh_back%0d: got state %0d expected 2", i, state);
      end
      tick();
    end
    tests_run++;
    if ({state, turn_right} !== {2'd3, 1'b1}) begin
      tests_failed++;
      $display("FAIL fresh_turn: got state %0d tr %0d expected state 3 tr 1", state, turn_right);
    end
    for (int i = 0; i < TURN_CYCLES; i++) tick();
    tests_run++;
    if (obs !== model_out()) begin
      tests_failed++;
      $display("FAIL manual_model: got %b expected %b", obs, model_out());
    end
  endtask

  task automatic test_saturation_reset();
    int exp_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if ({state, bump_cnt} !== {2'd1, 2'd0}) begin
      tests_failed++;
      $display("FAIL sat_start: got state %0d cnt %0d expected state 1 cnt 0", state, bump_cnt);
    end
    for (int e = 0; e < 5; e++) begin
      exp_cnt = (e + 1 < CNT_MAX) ? e + 1 : CNT_MAX;
      bump_pulse(1'b1, 1'b0);
      tick();
      tick();
      tests_run++;
      if (bump_cnt !== 2'(exp_cnt)) begin
        tests_failed++;
        $display("FAIL sat_cnt%0d: got %0d expected %0d", e, bump_cnt, exp_cnt);
      end
      if (e < 4) begin
        for (int i = 0; i < BACK_CYCLES + TURN_CYCLES; i++) tick();
      end
    end
    for (int i = 0; i < BACK_CYCLES + 1; i++) tick();   // second TURN clock
    tests_run++;
    if (state !== 2'd3) begin
      tests_failed++;
      $display("FAIL mid_turn: got state %0d expected 3", state);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if ({state, Len, Ren, bump_cnt} !== {2'd0, 2'b00, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset_mid_turn: got %b expected %b", {state, Len, Ren, bump_cnt}, {2'd0, 2'b00, 2'd0});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      run         = ($urandom_range(0, 15) != 0);
      manual_sel  = ($urandom_range(0, 31) == 0);
      manual_ldir = 1'($urandom_range(0, 1));
      manual_rdir = 1'($urandom_range(0, 1));
      bump_l_n    = ($urandom_range(0, 19) != 0);
      bump_r_n    = ($urandom_range(0, 19) != 0);
      case ($urandom_range(0, 15))
        0:       speed = 8'h00;
        1:       speed = 8'hFF;
        2:       speed = 8'($urandom_range(0, 255));
        default: ;
      endcase
      #1;
      tests_run++;
      if (obs !== model_out()) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: got %b expected %b", i, obs, model_out());
      end
      tick();
    end
    reset = 1'b0; manual_sel = 1'b0; bump_l_n = 1'b1; bump_r_n = 1'b1;
    #1;
    tests_run++;
    if (obs !== model_out()) begin
      tests_failed++;
      $display("FAIL random_final: got %b expected %b", obs, model_out());
    end
  endtask

  initial begin
    test_reset();
    test_run_fwd();
    test_bump_left();
    test_both_bumps();
    test_pwm();
    test_manual();
    test_saturation_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
